// File: rtl/ram64_pkg.sv
// Shared widths and types for the 8x16 register-file RAM.
// Optional RAM64_BYPASS_EN forwards write data to matching read ports.
package ram64_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/ram64_rd_port.sv
// One combinational read port: word select plus optional write forwarding.
// RAM64_BYPASS_EN adds the write-side inputs and the forwarding compare.
module ram64_rd_port
    import ram64_pkg::*;
#(
    parameter int P_DATA_W = ram64_pkg::DATA_W,
    parameter int P_ADDR_W = ram64_pkg::ADDR_W
) (
    input  logic [P_ADDR_W-1:0]                      rd_addr,
    input  logic [(2**P_ADDR_W)-1:0][P_DATA_W-1:0]   mem,
`ifdef RAM64_BYPASS_EN
    input  logic                                     wr_en,
    input  logic [P_ADDR_W-1:0]                      wr_addr,
    input  logic [P_DATA_W-1:0]                      wr_data,
`endif
    output logic [P_DATA_W-1:0]                      rd_data
);

    always_comb begin
        rd_data = mem[rd_addr];
`ifdef RAM64_BYPASS_EN
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_data = wr_data;
        end
`endif
    end

endmodule

// File: rtl/ram64.sv
// 2**ADDR_W x DATA_W register RAM, one write port, two async read ports.
// Define RAM64_BYPASS_EN to forward d_in to reads of the address being written.
module ram64
    import ram64_pkg::*;
#(
    parameter int DATA_W = ram64_pkg::DATA_W,
    parameter int ADDR_W = ram64_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] d_in,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] d_out_a,
    output logic [DATA_W-1:0] d_out_b
);

    localparam int NWORDS = 2 ** ADDR_W;

    logic [NWORDS-1:0][DATA_W-1:0] mem_q;
    logic [NWORDS-1:0][DATA_W-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (wr) begin
            mem_d[wr_addr] = d_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

`ifdef RAM64_BYPASS_EN
    // Forwarding must stay off while reset holds the array at zero.
    logic byp_en;
    assign byp_en = wr & reset;
`endif

    ram64_rd_port #(
        .P_DATA_W (DATA_W),
        .P_ADDR_W (ADDR_W)
    ) u_rd_a (
        .rd_addr (rd_addr_a),
        .mem     (mem_q),
`ifdef RAM64_BYPASS_EN
        .wr_en   (byp_en),
        .wr_addr (wr_addr),
        .wr_data (d_in),
`endif
        .rd_data (d_out_a)
    );

    ram64_rd_port #(
        .P_DATA_W (DATA_W),
        .P_ADDR_W (ADDR_W)
    ) u_rd_b (
        .rd_addr (rd_addr_b),
        .mem     (mem_q),
`ifdef RAM64_BYPASS_EN
        .wr_en   (byp_en),
        .wr_addr (wr_addr),
        .wr_data (d_in),
`endif
        .rd_data (d_out_b)
    );

endmodule

// File: tb/tb_ram64.sv
// Directed-vector bench for ram64; expectations follow RAM64_BYPASS_EN.
module tb_ram64;

    logic        clk;
    logic        reset;
    logic        wr;
    logic [2:0]  wr_addr;
    logic [15:0] d_in;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;
    logic [15:0] d_out_a;
    logic [15:0] d_out_b;

    int vectors;
    int miscompares;

    ram64 dut (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr),
        .wr_addr   (wr_addr),
        .d_in      (d_in),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .d_out_a   (d_out_a),
        .d_out_b   (d_out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic write_word(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        wr      = 1'b1;
        wr_addr = a;
        d_in    = d;
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    task automatic read_pair(input logic [2:0] a, input logic [2:0] b);
        rd_addr_a = a;
        rd_addr_b = b;
        #1;
    endtask

    logic [15:0] pre_edge_exp;

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        wr          = 1'b0;
        wr_addr     = 3'd0;
        d_in        = 16'h0000;
        rd_addr_a   = 3'd0;
        rd_addr_b   = 3'd1;
        #2;
        check("reset_a0", d_out_a, 16'h0000);
        check("reset_b1", d_out_b, 16'h0000);

        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_rel_a0", d_out_a, 16'h0000);

        // First write after release, visible right after its edge.
        read_pair(3'd0, 3'd1);
        write_word(3'd0, 16'hA5A5);
        check("vis_a0", d_out_a, 16'hA5A5);
        check("vis_b1_old", d_out_b, 16'h0000);
        write_word(3'd1, 16'h5A5A);
        read_pair(3'd0, 3'd1);
        check("wr_a0", d_out_a, 16'hA5A5);
        check("wr_b1", d_out_b, 16'h5A5A);

        write_word(3'd0, 16'h1234);
        read_pair(3'd0, 3'd1);
        check("ovw_a0", d_out_a, 16'h1234);
        check("keep_b1", d_out_b, 16'h5A5A);

        // Disabled writes must leave storage alone.
        @(negedge clk);
        wr      = 1'b0;
        wr_addr = 3'd2;
        d_in    = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        read_pair(3'd2, 3'd2);
        check("nowr_a2", d_out_a, 16'h0000);
        check("nowr_b2", d_out_b, 16'h0000);

        // Read-during-write on port A; port B on another address.
        @(negedge clk);
        rd_addr_a = 3'd3;
        rd_addr_b = 3'd4;
        wr        = 1'b1;
        wr_addr   = 3'd3;
        d_in      = 16'hBEEF;
        #1;
`ifdef RAM64_BYPASS_EN
        pre_edge_exp = 16'hBEEF;
`else
        pre_edge_exp = 16'h0000;
`endif
        check("rdw_pre_a3", d_out_a, pre_edge_exp);
        check("rdw_pre_b4", d_out_b, 16'h0000);
        @(posedge clk);
        #1;
        wr = 1'b0;
        #1;
        check("rdw_post_a3", d_out_a, 16'hBEEF);

        write_word(3'd7, 16'h0F0F);
        write_word(3'd6, 16'hF0F0);
        read_pair(3'd7, 3'd6);
        check("hi_a7", d_out_a, 16'h0F0F);
        check("hi_b6", d_out_b, 16'hF0F0);
        read_pair(3'd3, 3'd3);
        check("same_a3", d_out_a, 16'hBEEF);
        check("same_b3", d_out_b, 16'hBEEF);

        // Reset while writing: array clears at once and the write is lost.
        @(negedge clk);
        wr      = 1'b1;
        wr_addr = 3'd5;
        d_in    = 16'hCAFE;
        #1;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            read_pair(3'(i), 3'(7 - i));
            check($sformatf("rst_a%0d", i), d_out_a, 16'h0000);
            check($sformatf("rst_b%0d", 7 - i), d_out_b, 16'h0000);
        end
        @(posedge clk);
        #1;
        read_pair(3'd5, 3'd0);
        check("rst_edge_a5", d_out_a, 16'h0000);
        @(negedge clk);
        wr    = 1'b0;
        reset = 1'b1;
        #1;
        read_pair(3'd5, 3'd3);
        check("rel_a5", d_out_a, 16'h0000);
        check("rel_b3", d_out_b, 16'h0000);

        write_word(3'd5, 16'h1357);
        read_pair(3'd5, 3'd5);
        check("again_a5", d_out_a, 16'h1357);
        check("again_b5", d_out_b, 16'h1357);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram64.md
RAM64 -- requirements
Module: ram64

Interface
REQ-001 Parameter DATA_W, default 16, word width in bits.
REQ-002 Parameter ADDR_W, default 3, address width; depth is 2**ADDR_W (8 words).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 wr  input  1  write enable, sampled on rising clk.
REQ-006 wr_addr  input  ADDR_W  write address.
REQ-007 d_in  input  DATA_W  write data.
REQ-008 rd_addr_a  input  ADDR_W  read address, port A.
REQ-009 rd_addr_b  input  ADDR_W  read address, port B.
REQ-010 d_out_a  output  DATA_W  read data, port A.
REQ-011 d_out_b  output  DATA_W  read data, port B.

Function
REQ-012 Storage SHALL be a 2**ADDR_W x DATA_W register array; one write port and two independent read ports.
REQ-013 On rising clk with reset deasserted and wr=1, mem[wr_addr] SHALL take d_in; other words unchanged.
REQ-014 With wr=0, no word SHALL change.
REQ-015 Reads SHALL be asynchronous (combinational): d_out_a = mem[rd_addr_a] and d_out_b = mem[rd_addr_b], with zero clock latency.
REQ-016 A write SHALL become visible on read ports immediately after the capturing clock edge (same delta, no extra cycle).
REQ-017 Both ports reading the same address SHALL return identical data.
REQ-018 A read of the address being written in the current cycle SHALL return the old word until the edge, unless RAM64_BYPASS_EN is defined (REQ-024).
REQ-019 All addresses are fully decoded; no out-of-range case exists and there is no wrap logic.

Reset
REQ-020 While reset=0, every word SHALL be 0 asynchronously, so d_out_a and d_out_b SHALL read 0 for any address.
REQ-021 Reset SHALL take priority over a concurrent write; a write on an edge during reset is discarded.
REQ-022 After reset release, the first rising edge with wr=1 SHALL perform a normal write.

Configuration
REQ-023 The macro RAM64_BYPASS_EN SHALL select write-to-read forwarding.
REQ-024 With RAM64_BYPASS_EN defined: when wr=1, reset=1 and rd_addr_x == wr_addr, d_out_x SHALL equal d_in combinationally, independently per port.
REQ-025 Without RAM64_BYPASS_EN: read ports SHALL return stored contents only (REQ-018).

Structure
REQ-026 Package ram64_pkg SHALL hold DATA_W, ADDR_W and DEPTH defaults and the word_t (DATA_W-bit) and addr_t (ADDR_W-bit) typedefs.
REQ-027 Sub-module ram64_rd_port (address mux plus optional bypass) SHALL be instantiated twice, once per read port.

Verification
REQ-028 Reset=0 for one cycle, then release -> d_out_a at addr 0 and d_out_b at addr 1 read 16'h0000.
REQ-029 wr=1, addr 0 d_in=16'hA5A5, then addr 1 d_in=16'h5A5A; wr=0 -> rd_addr_a=0 gives 16'hA5A5, rd_addr_b=1 gives 16'h5A5A.
REQ-030 wr=1, addr 0 d_in=16'h1234, one edge, wr=0 -> rd_addr_a=0 gives 16'h1234; addr 1 still 16'h5A5A.
REQ-031 wr=0, d_in=16'hFFFF, wr_addr=2, several edges -> mem[2] remains 16'h0000.
REQ-032 wr=1 to addr 3 with d_in=16'hBEEF and rd_addr_a=3 before the edge -> old value without RAM64_BYPASS_EN, 16'hBEEF with it; after the edge 16'hBEEF in both builds.
REQ-033 Assert reset=0 while writing 16'hCAFE to addr 5 -> all words 0 immediately; after release mem[5] reads 16'h0000.
